// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction-fetch front end: owns the PC, fetches over req/valid, retires with branch select.
// Optional RETIRE_COUNT_EN macro adds retired/taken instruction counters.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instruction,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                BrTaken,
  input  logic                UncondBr,
  output logic                fetch_err
`ifdef RETIRE_COUNT_EN
  ,
  output logic [63:0]         retired_cnt,
  output logic [63:0]         taken_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              req_q, req_d;
  logic              ivalid_q, ivalid_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] off26, off19, next_pc;

  // Branch offsets are word offsets, sign-extended and scaled to bytes.
  always_comb begin
    off26   = {{(ADDR_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    off19   = {{(ADDR_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    next_pc = pc_q + ADDR_W'(4);
    if (BrTaken) begin
      next_pc = UncondBr ? (pc_q + off26) : (pc_q + off19);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          wait_d  = '0;
          state_d = S_HOLD;
        end else begin
          wait_d = wait_q + CNT_W'(1);
          if (wait_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    // Handshake/status outputs are registered copies of the next state.
    req_d    = (state_d == S_REQ);
    ivalid_d = (state_d == S_HOLD);
    err_d    = (state_d == S_ERR);
  end

`ifdef RETIRE_COUNT_EN
  logic        retire;
  logic [63:0] retired_q, retired_d;
  logic [63:0] taken_q, taken_d;

  always_comb begin
    retire    = (state_q == S_HOLD) && !stall;
    retired_d = retired_q;
    taken_d   = taken_q;
    if (retire) begin
      retired_d = retired_q + 64'd1;
      if (BrTaken) begin
        taken_d = taken_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      ivalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = ir_q;
  assign instr_pc       = pc_q;
  assign instr_valid    = ivalid_q;
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem/decoder stimulus, transaction-level reference model, directed pins.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h100;
  localparam int unsigned TIMEOUT  = 15;

  localparam int PH_RST  = 0;
  localparam int PH_IDLE = 1;
  localparam int PH_REQ  = 2;
  localparam int PH_HOLD = 3;
  localparam int PH_ERR  = 4;

  logic        clk;
  logic        reset_n;
  logic        stall, br_taken, uncond_br;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid, fetch_err;
`ifdef RETIRE_COUNT_EN
  logic [63:0] retired_cnt, taken_cnt;
`endif

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) imem_bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (imem_bus),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .stall       (stall),
    .BrTaken     (br_taken),
    .UncondBr    (uncond_br),
    .fetch_err   (fetch_err)
`ifdef RETIRE_COUNT_EN
    ,
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents: a few hand-placed branches, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h9E37_79B9_7F4A_7C15;
    case (a)
      64'h104: return 32'h1400_003F;  // B +0x3F words -> 0x200
      64'h108: return 32'h17FF_FFFF;  // B -1 word
      64'h200: return 32'hB400_0040;  // CBZ imm19=2
      64'h208: return 32'h17FF_FF7E;  // B -0x82 words -> 0x0
      64'h000: return 32'h17FF_FFFF;  // B -1 word -> top of address space
      default: return h[63:32];
    endcase
  endfunction

  // Driver knobs, written by the directed sequence away from the negedge.
  bit k_rand     = 1'b0;
  bit k_valid_en = 1'b1;
  bit k_stall    = 1'b0;
  bit k_br       = 1'b0;
  bit k_unc      = 1'b0;

  // Reference model state.
  int          ph = PH_RST;
  logic [63:0] m_pc = RESET_PC;
  logic [31:0] m_ir = '0;
  int          m_wait = 0;
  logic [63:0] m_ret = '0, m_tkn = '0;
  bit          p_vin = 0, p_stall = 0, p_br = 0, p_unc = 0;
  int          d_wait = 0;

  // Compare against the model, then drive next-cycle imem/decoder inputs.
  always @(negedge clk) begin
    bit v, s, b, u;
    longint off;
    if (!reset_n) begin
      chk("rst_req", imem_bus.imem_req, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_err", fetch_err, 0);
      chk("rst_instr_pc", instr_pc, RESET_PC);
      chk("rst_instr", instruction, 0);
      ph = PH_RST; m_pc = RESET_PC; m_wait = 0; m_ret = 0; m_tkn = 0;
    end else begin
      case (ph)
        PH_RST: begin
          chk("idle_req", imem_bus.imem_req, 0);
          chk("idle_ivalid", instr_valid, 0);
          ph = PH_IDLE;
        end
        PH_IDLE: begin
          chk("first_req", imem_bus.imem_req, 1);
          chk("first_addr", imem_bus.imem_addr, m_pc);
          chk("first_ivalid", instr_valid, 0);
          ph = PH_REQ; m_wait = 0;
        end
        PH_REQ: begin
          if (p_vin) begin
            m_ir = mem_word(m_pc);
            chk("fetch_ivalid", instr_valid, 1);
            chk("fetch_req_drop", imem_bus.imem_req, 0);
            chk("fetch_instr", instruction, m_ir);
            chk("fetch_pc", instr_pc, m_pc);
            ph = PH_HOLD;
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
              chk("timeout_req", imem_bus.imem_req, 0);
              chk("timeout_ivalid", instr_valid, 0);
              ph = PH_ERR;
            end else begin
              chk("wait_req", imem_bus.imem_req, 1);
              chk("wait_addr", imem_bus.imem_addr, m_pc);
              chk("wait_ivalid", instr_valid, 0);
            end
          end
        end
        PH_HOLD: begin
          if (p_stall) begin
            chk("stall_ivalid", instr_valid, 1);
            chk("stall_req", imem_bus.imem_req, 0);
            chk("stall_instr", instruction, m_ir);
            chk("stall_pc", instr_pc, m_pc);
          end else begin
            m_ret++;
            if (p_br) begin
              m_tkn++;
              if (p_unc) off = longint'($signed(m_ir[25:0]));
              else       off = longint'($signed(m_ir[23:5]));
              m_pc = m_pc + 64'(off * 4);
            end else begin
              m_pc = m_pc + 64'd4;
            end
            chk("retire_req", imem_bus.imem_req, 1);
            chk("retire_addr", imem_bus.imem_addr, m_pc);
            chk("retire_ivalid", instr_valid, 0);
            ph = PH_REQ; m_wait = 0;
          end
        end
        default: begin
          chk("err_req", imem_bus.imem_req, 0);
          chk("err_ivalid", instr_valid, 0);
        end
      endcase
      chk("err_flag", fetch_err, (ph == PH_ERR) ? 64'd1 : 64'd0);
    end
`ifdef RETIRE_COUNT_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("taken_cnt", taken_cnt, m_tkn);
`endif
    if (k_rand) begin
      if (imem_bus.imem_req) begin
        v = (d_wait >= int'(TIMEOUT) - 2) || ($urandom_range(0, 9) < 6);
        d_wait = v ? 0 : d_wait + 1;
      end else begin
        v = ($urandom_range(0, 3) == 0);
        d_wait = 0;
      end
      s = ($urandom_range(0, 3) == 0);
      b = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
    end else begin
      v = k_valid_en; s = k_stall; b = k_br; u = k_unc;
    end
    imem_bus.imem_valid = v;
    imem_bus.imem_rdata = imem_bus.imem_req ? mem_word(imem_bus.imem_addr) : $urandom();
    stall = s; br_taken = b; uncond_br = u;
    p_vin = v; p_stall = s; p_br = b; p_unc = u;
  end

  task automatic wait_req(input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!imem_bus.imem_req && n < 40);
    chk({name, "_req_seen"}, imem_bus.imem_req, 1);
  endtask

  task automatic wait_hold(input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!instr_valid && n < 40);
    chk({name, "_hold_seen"}, instr_valid, 1);
  endtask

  task automatic retire_one(input bit br, input bit unc, input logic [63:0] exp, input string name);
    wait_hold(name);
    k_br = br; k_unc = unc; k_stall = 1'b0;
    @(posedge clk); #2;
    chk({name, "_req"}, imem_bus.imem_req, 1);
    chk({name, "_addr"}, imem_bus.imem_addr, exp);
    k_br = 1'b0; k_unc = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Sequential fetch from the reset PC, then hand-placed branches.
    wait_req("t1_first");
    chk("t1_addr0", imem_bus.imem_addr, 64'h100);
    retire_one(1'b0, 1'b0, 64'h104, "t1_seq1");
    retire_one(1'b0, 1'b0, 64'h108, "t1_seq2");
    retire_one(1'b1, 1'b1, 64'h104, "t2_b_neg");
    retire_one(1'b1, 1'b1, 64'h200, "t2_b_fwd");
    retire_one(1'b1, 1'b0, 64'h208, "t2_cbz");

    // Five stalled cycles with branch low, then release with branch taken.
    wait_hold("t3");
    k_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("t3_stall_pc", instr_pc, 64'h208);
      chk("t3_stall_instr", instruction, 64'h17FF_FF7E);
      chk("t3_stall_req", imem_bus.imem_req, 0);
    end
    k_stall = 1'b0; k_br = 1'b1; k_unc = 1'b1;
    @(posedge clk); #2;
    chk("t3_release_addr", imem_bus.imem_addr, 64'h0);
    k_br = 1'b0; k_unc = 1'b0;

    retire_one(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "t5_to_top");
    retire_one(1'b0, 1'b0, 64'h0, "t5_wrap");
`ifdef RETIRE_COUNT_EN
    chk("t6_retired", retired_cnt, 64'd8);
    chk("t6_taken", taken_cnt, 64'd5);
`endif

    k_rand = 1'b1;
    repeat (3000) @(posedge clk);
    #2 k_rand = 1'b0; k_valid_en = 1'b1; k_stall = 1'b0;

    // Reset asserted while a request is outstanding.
    wait_req("t5_mid");
    reset_n = 1'b0;
    #1;
    chk("t5_mid_req_drop", imem_bus.imem_req, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    wait_req("t5_restart");
    chk("t5_restart_addr", imem_bus.imem_addr, RESET_PC);

    // imem never answers: fault after TIMEOUT request cycles.
    k_valid_en = 1'b0;
    n = 1;
    for (int i = 0; i < 40 && !fetch_err; i++) begin
      @(posedge clk); #2;
      if (imem_bus.imem_req) n++;
    end
    chk("t4_req_cycles", 64'(n), 64'(TIMEOUT));
    chk("t4_err", fetch_err, 1);
    chk("t4_req", imem_bus.imem_req, 0);
    k_valid_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("t4_err_sticky", fetch_err, 1);
    reset_n = 1'b0;
    #1;
    chk("t4_err_cleared", fetch_err, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    wait_req("t4_restart");
    chk("t4_restart_addr", imem_bus.imem_addr, RESET_PC);

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
